// File: rtl/seeg_pkg.sv
// Shared definitions for the seeg headstage interface: Intan opcodes, the
// configuration word table, job and FSM encodings, and command word helpers.
package seeg_pkg;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b10;
  localparam logic [5:0] ZSEL_REG   = 6'd6;

  // Each entry writes register r with value r.
  localparam logic [15:0] CFG_ROM [0:31] = '{
    16'h8000, 16'h8101, 16'h8202, 16'h8303, 16'h8404, 16'h8505, 16'h8606, 16'h8707,
    16'h8808, 16'h8909, 16'h8A0A, 16'h8B0B, 16'h8C0C, 16'h8D0D, 16'h8E0E, 16'h8F0F,
    16'h9010, 16'h9111, 16'h9212, 16'h9313, 16'h9414, 16'h9515, 16'h9616, 16'h9717,
    16'h9818, 16'h9919, 16'h9A1A, 16'h9B1B, 16'h9C1C, 16'h9D1D, 16'h9E1E, 16'h9F1F
  };

  typedef enum logic [1:0] {
    JOB_CONFIG,
    JOB_RECORD,
    JOB_ZCHECK
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_GAP,
    ST_FINISH
  } state_t;

  function automatic logic [15:0] convert_word(input logic [5:0] c);
    return {OP_CONVERT, c, 8'h00};
  endfunction

  function automatic logic [15:0] write_word(input logic [5:0] r, input logic [7:0] d);
    return {OP_WRITE, r, d};
  endfunction

endpackage

// File: rtl/intan_spi_responder_shifter.sv
// One 16-bit SPI transfer, MSB first. The start cycle is already the first
// low-phase cycle of the MSB, so a word takes exactly 32*SCLK_HALF cycles.
module spi_word_shifter #(
  parameter int SCLK_HALF = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tx_word,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic [15:0] rx_word,
  output logic        word_done
);

  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);

  logic          active;
  logic          high;
  logic [HW-1:0] half_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   rx_sh;
  logic          run;
  logic          half_end;

  assign run       = active | start;
  assign half_end  = (half_cnt == HALF_LAST);
  assign word_done = active & high & half_end & (bit_cnt == 4'd15);
  assign sclk      = high;
  // tx_word is held stable by the caller for the whole transfer.
  assign mosi      = run ? tx_word[~bit_cnt] : 1'b0;
  assign rx_word   = rx_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      high     <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      rx_sh    <= '0;
    end else if (run) begin
      if (!high && half_end) rx_sh <= {rx_sh[14:0], miso};
      if (half_end) begin
        half_cnt <= '0;
        high     <= ~high;
        if (high) bit_cnt <= bit_cnt + 4'd1;
      end else begin
        half_cnt <= half_cnt + HW'(1);
      end
      active <= ~word_done;
    end
  end

endmodule

// File: rtl/intan_spi_responder.sv
// Headstage job engine: turns config/record/zcheck requests into Intan SPI
// command word sequences and reports each captured MISO word.
module intan_spi_responder
  import seeg_pkg::*;
#(
  parameter int SCLK_HALF       = 2,
  parameter int CS_GAP          = 4,
  parameter int NUM_CH          = 4,
  parameter int CFG_WORDS       = 4,
  parameter int ZCHECK_CONVERTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        config_start,
  input  logic        record_start,
  input  logic        zcheck_start,
  input  logic [11:0] zcheck_global_channel,
  output logic        busy,
  output logic        done,
  output logic        CS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [15:0] rx_word,
  output logic [5:0]  rx_index,
  output logic        rx_valid,
  output state_t      dbg_state
);

  // Handshake: *_start are level requests sampled only in IDLE; the
  // controller holds one until busy=1, and busy falls the cycle after done.

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);
  localparam logic [GW-1:0] GAP_PRE  = (CS_GAP > 1) ? GW'(CS_GAP - 2) : '0;
  localparam bit            GAP_ONE  = (CS_GAP == 1);

  state_t        state, state_n;
  job_t          job;
  logic [5:0]    ch;
  logic [5:0]    w;
  logic [GW-1:0] gap_cnt;
  logic [6:0]    n_words;
  logic          last_word;
  logic          any_start;
  job_t          job_sel;
  logic [15:0]   cur_word;
  logic [15:0]   shift_rx;
  logic          word_done;
  logic          unused_ch_hi;

  assign unused_ch_hi = ^zcheck_global_channel[11:6];
  assign any_start    = config_start | record_start | zcheck_start;
  assign job_sel      = config_start ? JOB_CONFIG : (zcheck_start ? JOB_ZCHECK : JOB_RECORD);

  always_comb begin
    n_words  = 7'(NUM_CH);
    cur_word = convert_word(w);
    unique case (job)
      JOB_CONFIG: begin
        n_words  = 7'(CFG_WORDS);
        cur_word = CFG_ROM[w[4:0]];
      end
      JOB_ZCHECK: begin
        n_words  = 7'(ZCHECK_CONVERTS + 1);
        cur_word = (w == 6'd0) ? write_word(ZSEL_REG, {2'b00, ch}) : convert_word(ch);
      end
      default: begin
        n_words  = 7'(NUM_CH);
        cur_word = convert_word(w);
      end
    endcase
  end

  assign last_word = ({1'b0, w} == (n_words - 7'd1));

  spi_word_shifter #(.SCLK_HALF(SCLK_HALF)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (state == ST_LOAD),
    .tx_word   (cur_word),
    .miso      (MISO),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .rx_word   (shift_rx),
    .word_done (word_done)
  );

  // The last word's gap is one cycle short; FINISH supplies that final cycle.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:  if (any_start) state_n = ST_LOAD;
      ST_LOAD:  state_n = ST_SHIFT;
      ST_SHIFT: if (word_done) state_n = (last_word && GAP_ONE) ? ST_FINISH : ST_GAP;
      ST_GAP: begin
        if (last_word) begin
          if (gap_cnt == GAP_PRE) state_n = ST_FINISH;
        end else if (gap_cnt == GAP_LAST) begin
          state_n = ST_LOAD;
        end
      end
      ST_FINISH: state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      job      <= JOB_RECORD;
      ch       <= '0;
      w        <= '0;
      gap_cnt  <= '0;
      rx_word  <= '0;
      rx_index <= '0;
      rx_valid <= 1'b0;
    end else begin
      state    <= state_n;
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_start) begin
            job <= job_sel;
            ch  <= zcheck_global_channel[5:0];
            w   <= '0;
          end
        end
        ST_SHIFT: begin
          if (word_done) begin
            gap_cnt  <= '0;
            rx_word  <= shift_rx;
            rx_index <= w;
            rx_valid <= 1'b1;
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
          if (state_n == ST_LOAD) w <= w + 6'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FINISH);
  assign CS        = !((state == ST_LOAD) || (state == ST_SHIFT));
  assign dbg_state = state;

endmodule

// File: tb/tb_intan_spi_responder.sv
// Self-checking bench for intan_spi_responder: directed jobs from the test
// plan plus randomized jobs, checked against a word-list reference model.
module tb_intan_spi_responder;
  import seeg_pkg::*;

  localparam int SCLK_HALF       = 2;
  localparam int CS_GAP          = 4;
  localparam int NUM_CH          = 4;
  localparam int CFG_WORDS       = 4;
  localparam int ZCHECK_CONVERTS = 2;
  localparam int P               = 32 * SCLK_HALF + CS_GAP;
  localparam int J_CFG = 0, J_REC = 1, J_ZC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        config_start = 1'b0;
  logic        record_start = 1'b0;
  logic        zcheck_start = 1'b0;
  logic [11:0] zcheck_global_channel = '0;
  logic        busy, done, CS, SCLK, MOSI, MISO, rx_valid;
  logic [15:0] rx_word;
  logic [5:0]  rx_index;
  state_t      dbg_state;
  logic        miso_r  = 1'b0;
  logic        loop_en = 1'b0;

  assign MISO = loop_en ? MOSI : miso_r;

  intan_spi_responder #(
    .SCLK_HALF(SCLK_HALF), .CS_GAP(CS_GAP), .NUM_CH(NUM_CH),
    .CFG_WORDS(CFG_WORDS), .ZCHECK_CONVERTS(ZCHECK_CONVERTS)
  ) dut (
    .clk(clk), .rst(rst),
    .config_start(config_start), .record_start(record_start), .zcheck_start(zcheck_start),
    .zcheck_global_channel(zcheck_global_channel),
    .busy(busy), .done(done), .CS(CS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .rx_word(rx_word), .rx_index(rx_index), .rx_valid(rx_valid), .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: expected word list per job
  logic [15:0] cfg_tab [4] = '{16'h8000, 16'h8101, 16'h8202, 16'h8303};

  function automatic int n_words(input int jt);
    if (jt == J_CFG) return CFG_WORDS;
    if (jt == J_REC) return NUM_CH;
    return 1 + ZCHECK_CONVERTS;
  endfunction

  function automatic logic [15:0] model_word(input int jt, input int w, input logic [5:0] ch);
    if (jt == J_CFG) return cfg_tab[w];
    if (jt == J_REC) return 16'(w * 256);
    if (w == 0) return 16'(32768 + 6 * 256 + int'(ch));
    return 16'(int'(ch) * 256);
  endfunction

  // scoreboard / bus monitor
  logic [15:0] exp_q[$];
  logic [15:0] tx_q[$];
  logic [15:0] tx_sh     = '0;
  logic [15:0] miso_word = 16'hA5C3;
  logic        prev_sclk = 1'b0;
  int          bit_i     = 0;
  int          rx_cnt    = 0;
  int          rx_seen   = 0;
  int          done_seen = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_seen++;
      if (exp_q.size() == 0) check_eq("rx_expected_avail", 32'(exp_q.size()), 1);
      else begin
        check_eq("rx_word", rx_word, exp_q.pop_front());
        check_eq("rx_index", rx_index, rx_cnt);
      end
      rx_cnt++;
    end
    if (done) done_seen++;
    if (CS) begin
      bit_i  = 0;
      miso_r = miso_word[15];
    end else if (SCLK && !prev_sclk) begin
      tx_sh = {tx_sh[14:0], MOSI};
      bit_i++;
      if (bit_i == 16) begin
        tx_q.push_back(tx_sh);
        exp_q.push_back(loop_en ? tx_sh : miso_word);
        bit_i     = 0;
        miso_word = 16'($urandom);
      end
      miso_r = miso_word[15 - bit_i];
    end
    prev_sclk = SCLK;
  end

  // driver tasks
  task automatic clear_mon();
    tx_q.delete();
    exp_q.delete();
    rx_cnt = 0;
  endtask

  task automatic launch(input logic c, input logic z, input logic r,
                        input logic [11:0] ch, input logic keep_rec);
    int t = 0;
    clear_mon();
    zcheck_global_channel = ch;
    config_start = c;
    zcheck_start = z;
    record_start = r;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 20);
    check_eq("start_latency", t, 1);
    check_eq("load_cs", CS, 0);
    check_eq("load_sclk", SCLK, 0);
    config_start = 1'b0;
    zcheck_start = 1'b0;
    if (!keep_rec) record_start = 1'b0;
  endtask

  task automatic finish_job(input int jt, input logic [5:0] ch);
    int n = n_words(jt);
    int cnt = 0;
    int d0 = done_seen;
    logic seen = 1'b0;
    while (busy && !seen && cnt < 5000) begin
      cnt++;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check_eq("done_seen", seen, 1);
    check_eq("job_len", cnt, n * P);
    @(negedge clk);
    check_eq("busy_after_done", busy, 0);
    check_eq("done_pulse_count", done_seen - d0, 1);
    check_eq("word_count", tx_q.size(), n);
    check_eq("rx_count", rx_cnt, n);
    for (int i = 0; i < n && i < tx_q.size(); i++)
      check_eq($sformatf("mosi_w%0d", i), tx_q[i], model_word(jt, i, ch));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, d0, r0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_cs", CS, 1);
    check_eq("rst_sclk", SCLK, 0);
    check_eq("rst_mosi", MOSI, 0);
    check_eq("rst_rx_word", rx_word, 0);
    check_eq("rst_rx_index", rx_index, 0);
    check_eq("rst_rx_valid", rx_valid, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);

    // config job, loopback
    loop_en = 1'b1;
    launch(1, 0, 0, 12'h000, 0);
    finish_job(J_CFG, 6'd0);

    // record job, loopback
    launch(0, 0, 1, 12'h000, 0);
    finish_job(J_REC, 6'd0);

    // zcheck on channel 37 with random MISO data
    loop_en = 1'b0;
    launch(0, 1, 0, 12'd37, 0);
    finish_job(J_ZC, 6'd37);

    // priority: config wins, held record re-enters after one idle cycle
    launch(1, 0, 1, 12'h000, 1);
    finish_job(J_CFG, 6'd0);
    clear_mon();
    @(negedge clk);
    check_eq("reentry_busy", busy, 1);
    record_start = 1'b0;
    finish_job(J_REC, 6'd0);

    // zcheck_start pulsed mid-record has no effect
    launch(0, 0, 1, 12'd21, 0);
    fork
      finish_job(J_REC, 6'd0);
      begin
        repeat (90) @(negedge clk);
        zcheck_start = 1'b1;
        repeat (10) @(negedge clk);
        zcheck_start = 1'b0;
      end
    join
    @(negedge clk);
    check_eq("no_spurious_job", busy, 0);

    // reset during bit 7 of word 1
    launch(0, 0, 1, 12'h000, 0);
    t = 0;
    while (!(tx_q.size() == 1 && bit_i == 7) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_word1_bit7", 32'(t < 2000), 1);
    d0 = done_seen;
    r0 = rx_seen;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_cs", CS, 1);
    check_eq("midrst_sclk", SCLK, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_rx_valid", rx_valid, 0);
    check_eq("midrst_state", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    check_eq("midrst_no_done", done_seen - d0, 0);
    check_eq("midrst_no_rx", rx_seen - r0, 0);
    loop_en = 1'b1;
    launch(1, 0, 0, 12'h000, 0);
    finish_job(J_CFG, 6'd0);

    // randomized jobs with random competing lower-priority requests
    for (int k = 0; k < 6; k++) begin
      int jt;
      logic [11:0] ch;
      logic c, z, r;
      jt      = $urandom_range(0, 2);
      ch      = 12'($urandom);
      loop_en = 1'($urandom_range(0, 1));
      c = (jt == J_CFG);
      z = (jt == J_ZC) || (jt == J_CFG && $urandom_range(0, 1) == 1);
      r = (jt == J_REC) || (jt != J_REC && $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      launch(c, z, r, ch, 0);
      finish_job(jt, ch[5:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
